// File: rtl/data_mem_bridge_if.sv
// rtl/data_mem_bridge_if.sv - processor data-port bundle between the Memory stage and the bridge
// The master drives request, address and write data; the slave returns read data and the stall.
interface data_mem_bridge_if #(
  parameter int WORD_SIZE = 16
);
  logic [WORD_SIZE-1:0] DataAddr;
  logic [WORD_SIZE-1:0] DataOut;
  logic                 ReadData;
  logic                 WriteData;
  logic [WORD_SIZE-1:0] DataIn;
  logic                 DataWaitreq;

  modport master (
    output DataAddr, DataOut, ReadData, WriteData,
    input  DataIn, DataWaitreq
  );

  modport slave (
    input  DataAddr, DataOut, ReadData, WriteData,
    output DataIn, DataWaitreq
  );
endinterface

// File: rtl/data_mem_bridge.sv
// rtl/data_mem_bridge.sv - data-port slave decoding accesses to a word RAM or a 4-word MMIO block
// Stalls the Memory stage with a fixed latency per target; writes commit on the response edge.
module data_mem_bridge #(
  parameter int                   WORD_SIZE   = 16,
  parameter int                   RAM_DEPTH   = 256,
  parameter int                   RAM_LATENCY = 2,
  parameter logic [WORD_SIZE-1:0] MMIO_BASE   = 16'hF000
) (
  input  logic                 Clock,
  input  logic                 Reset,
  data_mem_bridge_if.slave     bus,
  input  logic [WORD_SIZE-1:0] Switches,
  output logic [WORD_SIZE-1:0] Leds,
  output logic                 BusError
);

  localparam int AW        = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int WAIT_LOAD = (RAM_LATENCY > 2) ? RAM_LATENCY - 2 : 0;
  localparam int CNT_W     = (WAIT_LOAD > 1) ? $clog2(WAIT_LOAD + 1) : 1;

  typedef enum logic [1:0] {IDLE, RAM_WAIT, RESP} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [AW-1:0]         r_ram_idx;
  logic [1:0]            r_off;
  logic [WORD_SIZE-1:0]  r_wdata;
  logic                  r_is_write;
  logic                  r_both;
  logic                  r_is_ram;
  logic                  r_is_mmio;
  logic [CNT_W-1:0]      r_cnt;
  logic [WORD_SIZE-1:0]  r_rdata;
  logic [WORD_SIZE-1:0]  r_leds;
  logic [WORD_SIZE-1:0]  r_timer;
  logic [WORD_SIZE-1:0]  r_sw_meta;
  logic [WORD_SIZE-1:0]  r_sw_sync;
  logic                  r_bus_error;
  logic [WORD_SIZE-1:0]  r_ram [0:RAM_DEPTH-1];

  logic                  w_req;
  logic                  w_in_ram;
  logic [WORD_SIZE-1:0]  w_in_off;
  logic                  w_in_mmio;
  logic [WORD_SIZE-1:0]  w_mmio_rdata;
  logic                  w_accept;
  logic                  w_capture;
  logic                  w_commit;

  assign w_req     = bus.ReadData | bus.WriteData;
  assign w_in_ram  = (bus.DataAddr < WORD_SIZE'(RAM_DEPTH));
  assign w_in_off  = bus.DataAddr - MMIO_BASE;
  assign w_in_mmio = !w_in_ram && (w_in_off < WORD_SIZE'(4));

  assign bus.DataWaitreq = Reset & w_req & (r_state != RESP);
  assign bus.DataIn      = (Reset && r_state == RESP) ? r_rdata : '0;
  assign Leds            = r_leds;
  assign BusError        = r_bus_error;

  always_comb begin
    w_mmio_rdata = '0;
    case (w_in_off[1:0])
      2'd0:    w_mmio_rdata = r_leds;
      2'd1:    w_mmio_rdata = r_sw_sync;
      2'd2:    w_mmio_rdata = r_timer;
      default: w_mmio_rdata = {{(WORD_SIZE-1){1'b0}}, r_bus_error};
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // The accept cycle counts as the first RAM wait cycle, so RAM_WAIT lasts RAM_LATENCY-1 cycles.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_accept = 1'b1;
          if (w_in_ram && RAM_LATENCY > 1) w_next_state = RAM_WAIT;
          else                             w_next_state = RESP;
        end
      end
      RAM_WAIT: begin
        if (!w_req) begin
          w_next_state = IDLE;
        end else if (r_cnt == '0) begin
          w_capture    = 1'b1;
          w_next_state = RESP;
        end
      end
      RESP: begin
        w_commit     = w_req;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (w_accept) begin
      r_ram_idx  <= bus.DataAddr[AW-1:0];
      r_off      <= w_in_off[1:0];
      r_wdata    <= bus.DataOut;
      r_is_write <= bus.WriteData;
      r_both     <= bus.ReadData & bus.WriteData;
      r_is_ram   <= w_in_ram;
      r_is_mmio  <= w_in_mmio;
    end
    if (Reset && w_commit && r_is_write && r_is_ram) r_ram[r_ram_idx] <= r_wdata;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_leds      <= '0;
      r_timer     <= '0;
      r_bus_error <= 1'b0;
      r_rdata     <= '0;
      r_sw_meta   <= '0;
      r_sw_sync   <= '0;
      r_cnt       <= '0;
    end else begin
      r_sw_meta <= Switches;
      r_sw_sync <= r_sw_meta;
      r_timer   <= r_timer + 1'b1;
      if (w_accept) begin
        r_cnt <= CNT_W'(WAIT_LOAD);
        if (w_in_ram && RAM_LATENCY == 1) r_rdata <= r_ram[bus.DataAddr[AW-1:0]];
        else if (!w_in_ram && !bus.WriteData) r_rdata <= w_in_mmio ? w_mmio_rdata : '0;
      end
      if (r_state == RAM_WAIT && w_req && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (w_capture) r_rdata <= r_ram[r_ram_idx];
      // Later assignments win: a timer clear beats the increment, a dual-request error beats a status clear.
      if (w_commit) begin
        if (r_is_write) begin
          if (r_is_mmio) begin
            case (r_off)
              2'd0:    r_leds      <= r_wdata;
              2'd1:    r_bus_error <= 1'b1;
              2'd2:    r_timer     <= '0;
              default: r_bus_error <= 1'b0;
            endcase
          end else if (!r_is_ram) begin
            r_bus_error <= 1'b1;
          end
          if (r_both) r_bus_error <= 1'b1;
        end else if (!r_is_ram && !r_is_mmio) begin
          r_bus_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_bridge.sv
// tb/tb_data_mem_bridge.sv - randomized and directed bench for data_mem_bridge against a transaction model
// The model tracks memory, LEDs, error flag and timer-clear time; a negedge process compares every cycle.
module tb_data_mem_bridge;
  localparam int          DEPTH = 256;
  localparam int          LAT   = 2;
  localparam logic [15:0] BASE  = 16'hF000;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] Switches = 16'h0;
  logic [15:0] Leds;
  logic        BusError;

  data_mem_bridge_if #(.WORD_SIZE(16)) bus();

  data_mem_bridge #(
    .WORD_SIZE(16), .RAM_DEPTH(DEPTH), .RAM_LATENCY(LAT), .MMIO_BASE(BASE)
  ) dut (
    .Clock(Clock), .Reset(Reset), .bus(bus),
    .Switches(Switches), .Leds(Leds), .BusError(BusError)
  );

  always #5 Clock = ~Clock;

  int          n_vec = 0;
  int          n_err = 0;
  int unsigned ecount = 0;
  bit          chk_en = 1'b0;

  logic [15:0] m_mem [0:DEPTH-1];
  logic [15:0] m_leds = 16'h0;
  logic        m_berr = 1'b0;
  logic [15:0] m_rd = 16'h0;
  int unsigned m_clear = 0;

  bit          t_active = 1'b0;
  int unsigned t_start = 0;
  int          t_lat = 0;
  logic [15:0] t_rdata = 16'h0;

  always @(posedge Clock) ecount <= ecount + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, ecount);
    end
  endtask

  always @(negedge Clock) begin
    if (chk_en) begin
      int          n;
      logic        ew;
      logic [15:0] ed;
      n  = int'(ecount - t_start) + 1;
      ew = Reset && t_active && (n < t_lat);
      ed = (Reset && t_active && n == t_lat) ? t_rdata : 16'h0;
      chk("waitreq", {15'h0, bus.DataWaitreq}, {15'h0, ew});
      chk("datain", bus.DataIn, ed);
      chk("leds", Leds, m_leds);
      chk("buserror", {15'h0, BusError}, {15'h0, m_berr});
    end
  end

  task automatic do_reset();
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(posedge Clock); #1;
    m_leds = 16'h0; m_berr = 1'b0; m_rd = 16'h0; t_active = 1'b0;
    Reset = 1'b1;
    m_clear = ecount;
    repeat (3) @(posedge Clock);
  endtask

  task automatic set_sw(input logic [15:0] v);
    @(posedge Clock); #1;
    Switches = v;
    repeat (3) @(posedge Clock);
  endtask

  task automatic txn(input logic [15:0] a, input logic [15:0] d, input bit rd, input bit wr,
                     input bit abort, output int lat_seen, output logic [15:0] din_seen);
    bit          is_ram, is_mmio, done;
    logic [1:0]  off;
    logic [15:0] rdv, t16;
    @(posedge Clock); #1;
    is_ram  = (a < 16'(DEPTH));
    t16     = a - BASE;
    off     = t16[1:0];
    is_mmio = !is_ram && (a >= BASE) && (a <= BASE + 16'd3);
    rdv = m_rd;
    if (is_ram) rdv = m_mem[a[7:0]];
    else if (!wr) begin
      if (!is_mmio)       rdv = 16'h0;
      else if (off == 0)  rdv = m_leds;
      else if (off == 1)  rdv = Switches;
      else if (off == 2)  rdv = 16'(ecount - m_clear);
      else                rdv = {15'h0, m_berr};
    end
    bus.DataAddr = a; bus.DataOut = d; bus.ReadData = rd; bus.WriteData = wr;
    t_start = ecount; t_lat = is_ram ? LAT + 1 : 2; t_rdata = rdv; t_active = 1'b1;
    lat_seen = 0; din_seen = 16'hxxxx;
    if (abort) begin
      @(posedge Clock); #1;
      bus.ReadData = 1'b0; bus.WriteData = 1'b0; t_active = 1'b0;
      @(posedge Clock); #1;
      return;
    end
    done = 1'b0;
    for (int c = 1; c <= 20 && !done; c++) begin
      @(negedge Clock);
      if (!bus.DataWaitreq) begin
        lat_seen = c; din_seen = bus.DataIn; done = 1'b1;
      end
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL timeout: DataWaitreq still 1 after 20 cycles, required 0 (addr %h)", a);
    end
    @(posedge Clock); #1;
    if (wr) begin
      if (is_ram) m_mem[a[7:0]] = d;
      else if (is_mmio) begin
        if (off == 0)      m_leds = d;
        else if (off == 1) m_berr = 1'b1;
        else if (off == 2) m_clear = ecount;
        else               m_berr = 1'b0;
      end else m_berr = 1'b1;
      if (rd) m_berr = 1'b1;
    end else if (!is_ram && !is_mmio) m_berr = 1'b1;
    m_rd = rdv;
    bus.ReadData = 1'b0; bus.WriteData = 1'b0; t_active = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [15:0] din, a, d;
    int          k, op;
    bit          rd, wr, ab;
    bus.DataAddr = 16'h0; bus.DataOut = 16'h0; bus.ReadData = 1'b0; bus.WriteData = 1'b0;
    do_reset();
    chk_en = 1'b1;
    @(negedge Clock);
    chk("rst_leds", Leds, 16'h0);
    chk("rst_berr", {15'h0, BusError}, 16'h0);

    for (int i = 0; i < DEPTH; i++) txn(16'(i), 16'($urandom), 1'b0, 1'b1, 1'b0, lat, din);

    txn(16'd5, 16'h1234, 1'b0, 1'b1, 1'b0, lat, din);
    chk("ram_wr_lat", 16'(lat), 16'd3);
    txn(16'd5, 16'h0, 1'b1, 1'b0, 1'b0, lat, din);
    chk("ram_rd_lat", 16'(lat), 16'd3);
    chk("ram_rd_data", din, 16'h1234);

    txn(BASE, 16'h00A5, 1'b0, 1'b1, 1'b0, lat, din);
    @(negedge Clock);
    chk("led_wr", Leds, 16'h00A5);
    txn(BASE, 16'h0, 1'b1, 1'b0, 1'b0, lat, din);
    chk("led_rd_lat", 16'(lat), 16'd2);
    chk("led_rd_data", din, 16'h00A5);

    set_sw(16'h0F0F);
    txn(BASE + 16'd1, 16'h0, 1'b1, 1'b0, 1'b0, lat, din);
    chk("sw_rd", din, 16'h0F0F);
    txn(BASE + 16'd1, 16'h1, 1'b0, 1'b1, 1'b0, lat, din);
    @(negedge Clock);
    chk("sw_wr_err", {15'h0, BusError}, 16'h1);
    txn(BASE + 16'd3, 16'h0, 1'b0, 1'b1, 1'b0, lat, din);
    @(negedge Clock);
    chk("status_clr", {15'h0, BusError}, 16'h0);

    txn(BASE + 16'd2, 16'h0, 1'b0, 1'b1, 1'b0, lat, din);
    repeat (10) @(posedge Clock);
    txn(BASE + 16'd2, 16'h0, 1'b1, 1'b0, 1'b0, lat, din);
    chk("timer_11", din, 16'd11);
    txn(BASE + 16'd2, 16'h0, 1'b0, 1'b1, 1'b0, lat, din);
    repeat (65537) @(posedge Clock);
    txn(BASE + 16'd2, 16'h0, 1'b1, 1'b0, 1'b0, lat, din);
    chk("timer_wrap", din, 16'd2);

    txn(16'h0400, 16'h0, 1'b1, 1'b0, 1'b0, lat, din);
    chk("unmap_lat", 16'(lat), 16'd2);
    chk("unmap_data", din, 16'h0);
    @(negedge Clock);
    chk("unmap_err", {15'h0, BusError}, 16'h1);
    txn(BASE + 16'd3, 16'h0, 1'b0, 1'b1, 1'b0, lat, din);
    txn(16'h0010, 16'h0007, 1'b1, 1'b1, 1'b0, lat, din);
    @(negedge Clock);
    chk("both_err", {15'h0, BusError}, 16'h1);
    txn(16'h0010, 16'h0, 1'b1, 1'b0, 1'b0, lat, din);
    chk("both_wr", din, 16'h0007);

    txn(16'd3, 16'h1111, 1'b0, 1'b1, 1'b0, lat, din);
    txn(16'd3, 16'hBEEF, 1'b0, 1'b1, 1'b1, lat, din);
    txn(16'd3, 16'h0, 1'b1, 1'b0, 1'b0, lat, din);
    chk("abort_keep", din, 16'h1111);

    txn(BASE, 16'h5A5A, 1'b0, 1'b1, 1'b0, lat, din);
    @(posedge Clock); #1;
    bus.DataAddr = 16'd7; bus.ReadData = 1'b1;
    t_start = ecount; t_lat = LAT + 1; t_rdata = m_mem[7]; t_active = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0; t_active = 1'b0;
    @(negedge Clock);
    chk("rst_mid_waitreq", {15'h0, bus.DataWaitreq}, 16'h0);
    @(posedge Clock); #1;
    m_leds = 16'h0; m_berr = 1'b0; m_rd = 16'h0;
    bus.ReadData = 1'b0; Reset = 1'b1; m_clear = ecount;
    @(negedge Clock);
    chk("rst_mid_leds", Leds, 16'h0);
    repeat (3) @(posedge Clock);

    for (int i = 0; i < 400; i++) begin
      k  = $urandom_range(0, 9);
      d  = 16'($urandom);
      op = $urandom_range(0, 5);
      rd = (op <= 2); wr = (op == 3 || op == 4); ab = 1'b0;
      if (k == 9) begin
        set_sw(16'($urandom));
      end else begin
        if (k <= 5)      a = 16'($urandom_range(0, DEPTH - 1));
        else if (k <= 7) a = BASE + 16'($urandom_range(0, 3));
        else if (k == 8 && op[0]) a = 16'($urandom_range(32'hF004, 32'hFFFF));
        else             a = 16'($urandom_range(DEPTH, 32'hEFFF));
        if (op == 5) begin
          if (k <= 5 && d[0]) begin rd = 1'b1; wr = 1'b1; end
          else if (k <= 5)    begin wr = 1'b1; ab = 1'b1; end
          else                rd = 1'b1;
        end
        txn(a, d, rd, wr, ab, lat, din);
      end
    end

    repeat (3) @(posedge Clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
